// File: rtl/sru_event_scheduler.sv
// sru_event_scheduler: latches spikes as pending events and time-multiplexes one SRU across them.
// Round-robin grant, fixed spike window, then a drain gap before the next grant.
module sru_event_scheduler #(
    parameter int N_IN    = 8,
    parameter int ID_W    = 3,
    parameter int W_W     = 4,
    parameter int WIN_LEN = 11,
    parameter int GAP     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] spike_in,
    input  logic            cfg_we,
    input  logic [ID_W-1:0] cfg_addr,
    input  logic [W_W-1:0]  cfg_wi,
    input  logic            cfg_ein,
    output logic            sru_E_plus,
    output logic [W_W-1:0]  sru_wi,
    output logic            sru_Ein,
    output logic [ID_W-1:0] active_id,
    output logic            busy,
    output logic            event_done,
    output logic [N_IN-1:0] pending,
    output logic [7:0]      drop_cnt
);
    localparam int CNT_W = $clog2((WIN_LEN > GAP ? WIN_LEN : GAP) + 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] rr_ptr, gnt_id, idx;
    logic            found;
    logic [N_IN-1:0] clr, drop;
    logic [8:0]      ndrop, sum;
    logic [W_W-1:0]  wi_tbl [N_IN];
    logic [N_IN-1:0] ein_tbl;

    // first pending line strictly after the last served one, wrapping
    always_comb begin
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_IN; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_IN);
            if (!found && pending[idx]) begin
                gnt_id = idx;
                found  = 1'b1;
            end
        end
    end

    assign clr  = (state == IDLE && found) ? ({{(N_IN-1){1'b0}}, 1'b1} << gnt_id) : '0;
    assign drop = spike_in & pending & ~clr;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < N_IN; i++)
            ndrop = ndrop + 9'(drop[i]);
    end

    assign sum = {1'b0, drop_cnt} + ndrop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            drop_cnt <= '0;
            ein_tbl  <= '1;
            for (int i = 0; i < N_IN; i++)
                wi_tbl[i] <= '0;
        end else begin
            pending  <= (pending & ~clr) | spike_in;
            drop_cnt <= sum[8] ? 8'hFF : sum[7:0];
            if (cfg_we) begin
                wi_tbl[cfg_addr]  <= cfg_wi;
                ein_tbl[cfg_addr] <= cfg_ein;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= ID_W'(N_IN - 1);
            sru_E_plus <= 1'b0;
            sru_wi     <= '0;
            sru_Ein    <= 1'b1;
            active_id  <= '0;
            busy       <= 1'b0;
            event_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state      <= RUN;
                    active_id  <= gnt_id;
                    sru_wi     <= wi_tbl[gnt_id];
                    sru_Ein    <= ein_tbl[gnt_id];
                    sru_E_plus <= 1'b1;
                    busy       <= 1'b1;
                    cnt        <= '0;
                end
                RUN: if (cnt == WIN_LAST) begin
                    state      <= DRAIN;
                    sru_E_plus <= 1'b0;
                    cnt        <= '0;
                    event_done <= (GAP_LAST == '0);
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DRAIN: if (cnt == GAP_LAST) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    event_done <= 1'b0;
                    rr_ptr     <= active_id;
                end else begin
                    cnt        <= cnt + 1'b1;
                    event_done <= (cnt + 1'b1 == GAP_LAST);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sru_event_scheduler.sv
// tb_sru_event_scheduler: directed stimulus; expected grants queued at issue time and
// checked by an independent monitor together with window, busy and event_done timing.
module tb_sru_event_scheduler;
    localparam int WIN_LEN = 11;
    localparam int GAP     = 2;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] wi;
        logic       ein;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] spike_in;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_wi;
    logic       cfg_ein;
    logic       sru_E_plus;
    logic [3:0] sru_wi;
    logic       sru_Ein;
    logic [2:0] active_id;
    logic       busy;
    logic       event_done;
    logic [7:0] pending;
    logic [7:0] drop_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   chk_gap = 0;

    sru_event_scheduler #(.N_IN(8), .ID_W(3), .W_W(4), .WIN_LEN(WIN_LEN), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wi(cfg_wi), .cfg_ein(cfg_ein), .sru_E_plus(sru_E_plus), .sru_wi(sru_wi),
        .sru_Ein(sru_Ein), .active_id(active_id), .busy(busy), .event_done(event_done),
        .pending(pending), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int wi, input int ein);
        exp_t e;
        e.id  = 3'(id);
        e.wi  = 4'(wi);
        e.ein = 1'(ein);
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pending != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < 500), 1);
    endtask

    // monitor: grant contents, window length, busy length, event_done placement
    int   cyc = 0, last_rise = 0, hi = 0, bc = 0, dn = 0;
    bit   prev_e = 0, prev_b = 0, have_rise = 0, ld = 0;
    exp_t e_m;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            prev_e = 0; prev_b = 0; hi = 0; bc = 0; dn = 0; have_rise = 0;
        end else begin
            if (sru_E_plus && !prev_e) begin
                chk("grant_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e_m = q.pop_front();
                    chk("grant_id", 32'(active_id), 32'(e_m.id));
                    chk("grant_wi", 32'(sru_wi), 32'(e_m.wi));
                    chk("grant_ein", 32'(sru_Ein), 32'(e_m.ein));
                end
                if (chk_gap && have_rise) chk("grant_spacing", 32'(cyc - last_rise), 14);
                last_rise = cyc; have_rise = 1; hi = 0;
            end
            if (sru_E_plus) hi++;
            if (!sru_E_plus && prev_e) chk("win_len", 32'(hi), WIN_LEN);
            if (busy) begin
                bc++;
                dn += int'(event_done);
                ld = event_done;
            end else if (prev_b) begin
                chk("busy_len", 32'(bc), WIN_LEN + GAP);
                chk("done_count", 32'(dn), 1);
                chk("done_last", 32'(ld), 1);
                bc = 0; dn = 0;
            end
            prev_e = sru_E_plus;
            prev_b = busy;
        end
    end

    initial begin
        int n;
        reset = 1'b0; spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wi = '0; cfg_ein = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_eplus", 32'(sru_E_plus), 0);
        chk("rst_wi", 32'(sru_wi), 0);
        chk("rst_ein", 32'(sru_Ein), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_done", 32'(event_done), 0);
        chk("rst_active", 32'(active_id), 0);
        reset = 1'b1;
        @(negedge clk);

        // all lines at once: default config readback and round-robin order
        chk_gap = 1;
        for (int i = 0; i < 8; i++) push(i, 0, 1);
        spike_in = 8'hFF;
        @(negedge clk);
        spike_in = '0;
        chk("ff_pending0", 32'(pending), 8'hFF);
        chk("ff_eplus_pre", 32'(sru_E_plus), 0);
        @(negedge clk);
        chk("ff_pending1", 32'(pending), 8'hFE);
        chk("ff_eplus_on", 32'(sru_E_plus), 1);
        chk("ff_busy", 32'(busy), 1);
        repeat (14) @(negedge clk);
        chk("ff_pending2", 32'(pending), 8'hFC);
        chk("ff_active2", 32'(active_id), 1);
        wait_idle();
        chk("ff_drop", 32'(drop_cnt), 0);
        chk_gap = 0;

        // configured line 3, latency of two edges from sample to window
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wi = 4'd9; cfg_ein = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        push(3, 9, 0);
        spike_in = 8'h08;
        @(negedge clk);
        spike_in = '0;
        chk("lat_eplus_pre", 32'(sru_E_plus), 0);
        chk("lat_pending", 32'(pending), 8'h08);
        @(negedge clk);
        chk("lat_eplus_on", 32'(sru_E_plus), 1);
        wait_idle();
        chk("idle_hold_id", 32'(active_id), 3);
        chk("idle_hold_wi", 32'(sru_wi), 9);
        chk("idle_hold_ein", 32'(sru_Ein), 0);

        // serve 5, then 2 and 6 pend together: 6 wins; cfg write during RUN is not seen
        push(5, 0, 1);
        spike_in = 8'h20;
        @(negedge clk);
        spike_in = '0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wi = 4'd7; cfg_ein = 1'b1;
        spike_in = 8'h44;
        push(6, 0, 1);
        push(2, 0, 1);
        @(negedge clk);
        cfg_we = 1'b0;
        spike_in = '0;
        repeat (2) @(negedge clk);
        chk("snap_wi", 32'(sru_wi), 0);
        chk("snap_active", 32'(active_id), 5);
        chk("snap_pending", 32'(pending), 8'h44);
        wait_idle();

        // drops: line 1 spiked three times while line 0 is served
        push(0, 0, 1);
        push(1, 0, 1);
        spike_in = 8'h01;
        @(negedge clk);
        spike_in = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            spike_in = 8'h02;
            @(negedge clk);
            spike_in = '0;
            @(negedge clk);
        end
        chk("drop_two", 32'(drop_cnt), 2);
        chk("drop_pending", 32'(pending), 8'h02);
        wait_idle();
        chk("drop_final", 32'(drop_cnt), 2);

        // continuous load: sequential round robin from line 2, drop counter saturates
        for (int i = 0; i < 40; i++) begin
            n = (2 + i) % 8;
            push(n, n == 3 ? 9 : (n == 5 ? 7 : 0), n == 3 ? 0 : 1);
        end
        spike_in = 8'hFF;
        repeat (300) @(negedge clk);
        spike_in = '0;
        chk("drop_sat", 32'(drop_cnt), 255);

        // abort in the fifth RUN cycle of the next window
        n = 0;
        while (sru_E_plus && n < 40) begin @(negedge clk); n++; end
        while (!sru_E_plus && n < 80) begin @(negedge clk); n++; end
        chk("abort_window_found", 32'(n < 80), 1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_eplus", 32'(sru_E_plus), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pending", 32'(pending), 0);
        chk("abort_drop", 32'(drop_cnt), 0);
        chk("abort_wi", 32'(sru_wi), 0);
        chk("abort_ein", 32'(sru_Ein), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push(0, 0, 1);
        push(4, 0, 1);
        spike_in = 8'h11;
        @(negedge clk);
        spike_in = '0;
        @(negedge clk);
        chk("post_rst_first", 32'(active_id), 0);
        wait_idle();
        chk("post_rst_last", 32'(active_id), 4);
        chk("post_rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
